// File: rtl/fifo_rd_stream_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_if
// Bundles the two sides of the read-side drain stage:
//   fifo side   : rempty, rdata (show-ahead head word), rd (pop strobe)
//   stream side : m_valid, m_ready, m_data, m_last, burst_done, burst_cnt
// Modports
//   master : the drain stage (drives rd and the stream outputs)
//   slave  : its environment (fifo read port plus downstream consumer)
// -----------------------------------------------------------------------------
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8,
  parameter int BCNTW = 8
);
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rd;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
  logic             m_last;
  logic             burst_done;
  logic [BCNTW-1:0] burst_cnt;

  modport master (
    input  rempty, rdata, m_ready,
    output rd, m_valid, m_data, m_last, burst_done, burst_cnt
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rd, m_valid, m_data, m_last, burst_done, burst_cnt
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
// Drains a show-ahead async-fifo read port into a valid/ready stream through a
// 2-entry skid buffer (head + skid) and frames the stream into BURST-beat
// bursts with a last flag, a burst-done pulse and a wrapping burst counter.
// Ports
//   rclk : read clock (fifo read-side clock)
//   rrst : asynchronous active-high reset
//   bus  : fifo_rd_stream_if.master
//          rempty/rdata in, rd out            (fifo read port)
//          m_ready in, m_valid/m_data/m_last  (output stream)
//          burst_done/burst_cnt out           (burst bookkeeping)
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int BURST = 4,
  parameter int BCNTW = 8
) (
  input  logic                    rclk,
  input  logic                    rrst,
  fifo_rd_stream_if.master        bus
);

  localparam int            BW        = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic [DSIZE-1:0] head;
  logic [DSIZE-1:0] skid;
  logic [BW-1:0]    beat;
  logic             done;
  logic [BCNTW-1:0] bcnt;
  logic             rd;
  logic             valid;
  logic             xfer;
  logic             last;

  // Pop only from flops and the fifo flag so no path exists from m_ready to rd;
  // a full buffer refuses the pop even if the consumer accepts this cycle.
  assign rd    = ~rrst & ~bus.rempty & (occ != 2'd2);
  assign valid = (occ != 2'd0);
  assign xfer  = valid & bus.m_ready;
  assign last  = valid & (beat == LAST_BEAT);

  assign bus.rd         = rd;
  assign bus.m_valid    = valid;
  assign bus.m_data     = head;
  assign bus.m_last     = last;
  assign bus.burst_done = done;
  assign bus.burst_cnt  = bcnt;

  // Occupancy update: +1 on pop, -1 on transfer, unchanged on both or neither.
  always_comb begin
    occ_next = occ;
    case ({rd, xfer})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Skid buffer data path, burst beat counter and burst bookkeeping.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ  <= 2'd0;
      head <= '0;
      skid <= '0;
      beat <= '0;
      done <= 1'b0;
      bcnt <= '0;
    end else begin
      occ <= occ_next;
      case (occ)
        2'd0: begin
          if (rd) head <= bus.rdata;
        end
        2'd1: begin
          // Head leaving while a new word arrives: bypass skid entirely.
          if (rd && xfer)  head <= bus.rdata;
          else if (rd)     skid <= bus.rdata;
        end
        2'd2: begin
          if (xfer) head <= skid;
        end
        default: begin
          head <= head;
        end
      endcase

      if (xfer) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      end
      done <= xfer & last;
      if (xfer && last) begin
        bcnt <= bcnt + BCNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Bench for fifo_rd_stream. A queue models the fifo contents; every pushed word
// also goes into a scoreboard queue. A negedge monitor predicts the stream from
// word counts (buffered = popped - transferred, beat = transfers mod BURST) and
// compares rd, m_valid, m_last, m_data, burst_done and burst_cnt.
// BCNTW is 2 so the burst counter wraps within the run.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;
  localparam int BURST = 4;
  localparam int BCNTW = 2;

  logic rclk = 1'b0;
  logic rrst = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_stream_if #(.DSIZE(DSIZE), .BCNTW(BCNTW)) bus ();

  fifo_rd_stream #(.DSIZE(DSIZE), .BURST(BURST), .BCNTW(BCNTW)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int               bc_hist[$];

  int         occ_m = 0;
  int         beat_m = 0;
  int         bc_m = 0;
  logic       bd_m = 1'b0;
  logic       rd_s = 1'b0;
  logic       stall_prev = 1'b0;
  logic [DSIZE-1:0] prev_data = '0;
  logic       prev_last = 1'b0;
  int         rd_pulses = 0;
  int         done_pulses = 0;
  logic       e_rd, e_valid, e_last, e_xfer;
  logic [DSIZE-1:0] e_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    bus.rempty = (fifo_q.size() == 0);
    if (fifo_q.size() > 0) bus.rdata = fifo_q[0];
  endtask

  task automatic push(input logic [DSIZE-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  // One clock: the model fifo drops its head if the DUT popped at this edge.
  task automatic cycle();
    @(posedge rclk);
    #1;
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd"},         32'(bus.rd),         32'd0);
    chk({tag, "_m_valid"},    32'(bus.m_valid),    32'd0);
    chk({tag, "_m_data"},     32'(bus.m_data),     32'd0);
    chk({tag, "_m_last"},     32'(bus.m_last),     32'd0);
    chk({tag, "_burst_done"}, 32'(bus.burst_done), 32'd0);
    chk({tag, "_burst_cnt"},  32'(bus.burst_cnt),  32'd0);
  endtask

  // Monitor / scoreboard on the inactive edge.
  always @(negedge rclk) begin
    if (rrst) begin
      occ_m = 0; beat_m = 0; bc_m = 0; bd_m = 1'b0;
      rd_s = 1'b0; stall_prev = 1'b0;
    end else begin
      e_valid = (occ_m > 0);
      e_rd    = !bus.rempty && (occ_m < 2);
      e_last  = e_valid && (beat_m == BURST - 1);
      chk("occ_range",  32'(dut.occ <= 2'd2),   32'd1);
      chk("rd",         32'(bus.rd),            32'(e_rd));
      chk("m_valid",    32'(bus.m_valid),       32'(e_valid));
      chk("m_last",     32'(bus.m_last),        32'(e_last));
      chk("burst_done", 32'(bus.burst_done),    32'(bd_m));
      chk("burst_cnt",  32'(bus.burst_cnt),     32'(bc_m));
      if (stall_prev) begin
        chk("hold_data", 32'(bus.m_data), 32'(prev_data));
        chk("hold_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (bus.burst_done) begin
        done_pulses++;
        bc_hist.push_back(int'(bus.burst_cnt));
      end
      rd_s = bus.rd;
      if (bus.rd) rd_pulses++;
      e_xfer = e_valid && bus.m_ready;
      if (e_xfer) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty: got %0h expected none", bus.m_data);
        end else begin
          e_word = exp_q.pop_front();
          chk("m_data", 32'(bus.m_data), 32'(e_word));
        end
      end
      occ_m  = occ_m + (e_rd ? 1 : 0) - (e_xfer ? 1 : 0);
      bd_m   = e_xfer && (beat_m == BURST - 1);
      if (e_xfer) beat_m = (beat_m + 1) % BURST;
      if (bd_m)   bc_m = (bc_m + 1) % (1 << BCNTW);
      stall_prev = e_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  int exp_seq[5] = '{1, 2, 3, 0, 1};
  int pushed;
  int budget;

  initial begin
    bus.rempty  = 1'b1;
    bus.rdata   = '0;
    bus.m_ready = 1'b0;
    #1 rrst = 1'b1;
    #1 check_zero("init");

    // Latency / throughput: 8 preloaded words, consumer always ready.
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    bus.m_ready = 1'b1;
    repeat (2) cycle();
    rrst = 1'b0;
    done_pulses = 0;
    repeat (14) cycle();
    chk("t2_burst_cnt", 32'(bus.burst_cnt), 32'd2);
    chk("t2_done_pulses", 32'(done_pulses), 32'd2);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: consumer stalls 5 cycles with fifo non-empty.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i));
    rd_pulses = 0;
    repeat (5) cycle();
    chk("t3_rd_pulses", 32'(rd_pulses), 32'd2);
    chk("t3_head", 32'(bus.m_data), 32'h20);
    bus.m_ready = 1'b1;
    repeat (14) cycle();
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // Mid-burst stall: 2 words, gap, 2 words.
    done_pulses = 0;
    push(8'h30); push(8'h31);
    repeat (12) cycle();
    chk("t4_no_done_yet", 32'(done_pulses), 32'd0);
    push(8'h32); push(8'h33);
    repeat (6) cycle();
    chk("t4_done_pulses", 32'(done_pulses), 32'd1);

    // Async reset with a full buffer.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h50 + i));
    repeat (4) cycle();
    chk("t1_occ_full", 32'(dut.occ), 32'd2);
    #2 rrst = 1'b1;
    #1 check_zero("t1_async");
    fifo_q.delete();
    exp_q.delete();
    rd_s = 1'b0;
    refresh();
    repeat (2) cycle();
    rrst = 1'b0;
    #1;
    chk("t1_occ_after", 32'(dut.occ), 32'd0);
    chk("t1_beat_after", 32'(dut.beat), 32'd0);

    // Burst counter wrap: 5 bursts from reset.
    bc_hist.delete();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) push(8'(8'h40 + i));
    repeat (26) cycle();
    chk("t6_bursts", 32'(bc_hist.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < bc_hist.size()) chk("t6_seq", 32'(bc_hist[i]), 32'(exp_seq[i]));
    end

    // Random fill and random backpressure over 1000 words.
    pushed = 0;
    budget = 0;
    while ((pushed < 1000 || exp_q.size() > 0) && budget < 20000) begin
      cycle();
      budget++;
      if (pushed < 1000 && ($urandom % 3) != 0) begin
        push(8'($urandom));
        pushed++;
      end
      bus.m_ready = (pushed < 1000) ? (($urandom % 4) != 0) : 1'b1;
    end
    repeat (4) cycle();
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    chk("t5_pushed", 32'(pushed), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
